// File: rtl/excp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : excp_ctrl
// Brief    : Trap sequencer for the single-cycle RV64I core. On a taken trap
//            or mret it stalls the core, issues the CSR updates one per cycle
//            through the shared CSR write port, then redirects the PC.
// Revision : 1.0 - initial release
// ============================================================================
module excp_ctrl #(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            id_ilegl_instr_i,
  input  logic            id_ecall_i,
  input  logic            id_ebreak_i,
  input  logic            id_mret_i,
  input  logic            irq_ext_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic            csr_meie_i,
  output logic            excp_csr_wen_o,
  output logic [11:0]     excp_csr_idx_o,
  output logic [XLEN-1:0] excp_csr_wdata_o,
  output logic            excp_stall_o,
  output logic            excp_redirect_o,
  output logic [XLEN-1:0] excp_redirect_pc_o,
  output logic            excp_busy_o
);

  // Sequencer states
  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_W_MEPC    = 3'd1;
  localparam logic [2:0] c_W_MCAUSE  = 3'd2;
  localparam logic [2:0] c_W_MTVAL   = 3'd3;
  localparam logic [2:0] c_W_MSTATUS = 3'd4;
  localparam logic [2:0] c_R_MSTATUS = 3'd5;
  localparam logic [2:0] c_REDIRECT  = 3'd6;

  // CSR addresses
  localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] c_ADDR_MTVAL   = 12'h343;

  // mcause encodings
  localparam logic [XLEN-1:0] c_CAUSE_IRQ    = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
  localparam logic [XLEN-1:0] c_CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] c_CAUSE_EBREAK = XLEN'(3);
  localparam logic [XLEN-1:0] c_CAUSE_ECALL  = XLEN'(11);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] epc_q, cause_q, tval_q, mstatus_q, tgt_q;

  logic            w_idle;
  logic            w_irq;
  logic            w_trap;
  logic            w_take_trap;
  logic            w_take_mret;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_tval;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_tgt;
  logic [XLEN-1:0] w_mst_trap;
  logic [XLEN-1:0] w_mst_mret;
  logic            w_unused;

  // RESET_PC only documents the core's reset vector; it drives no logic here
  assign w_unused = ^RESET_PC;

  // Take qualification: only from IDLE with a valid instruction. rst_n gates
  // the take so that every output is low while reset is held.
  assign w_idle      = (state_q == c_IDLE);
  assign w_irq       = irq_ext_i & csr_meie_i & csr_mstatus_i[3];
  assign w_trap      = w_irq | id_ilegl_instr_i | id_ebreak_i | id_ecall_i;
  assign w_take_trap = rst_n & w_idle & instr_valid_i & w_trap;
  assign w_take_mret = rst_n & w_idle & instr_valid_i & ~w_trap & id_mret_i;

  // Cause and trap value selection by priority: irq, illegal, ebreak, ecall
  always_comb begin
    w_cause = c_CAUSE_ECALL;
    w_tval  = '0;
    if (w_irq) begin
      w_cause = c_CAUSE_IRQ;
    end else if (id_ilegl_instr_i) begin
      w_cause = c_CAUSE_ILLEGAL;
      w_tval  = {{(XLEN-32){1'b0}}, instr_i};
    end else if (id_ebreak_i) begin
      w_cause = c_CAUSE_EBREAK;
      w_tval  = pc_i;
    end
  end

  // Handler address; vectored mode offsets interrupts only (wraps mod 2^XLEN)
  assign w_base = {csr_mtvec_i[XLEN-1:2], 2'b00};
  assign w_trap_tgt = (w_irq && (csr_mtvec_i[1:0] == 2'b01))
                    ? w_base + {{(XLEN-6){1'b0}}, w_cause[3:0], 2'b00}
                    : w_base;

  // New mstatus values derived from the snapshot taken at the take cycle
  always_comb begin
    w_mst_trap        = mstatus_q;
    w_mst_trap[7]     = mstatus_q[3];
    w_mst_trap[3]     = 1'b0;
    w_mst_trap[12:11] = 2'b11;
    w_mst_mret        = mstatus_q;
    w_mst_mret[3]     = mstatus_q[7];
    w_mst_mret[7]     = 1'b1;
    w_mst_mret[12:11] = 2'b11;
  end

  // Capture trap context at the take; frozen for the rest of the sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q     <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      tgt_q     <= '0;
    end else if (w_take_trap || w_take_mret) begin
      epc_q     <= pc_i;
      cause_q   <= w_cause;
      tval_q    <= w_tval;
      mstatus_q <= csr_mstatus_i;
      tgt_q     <= w_take_mret ? csr_mepc_i : w_trap_tgt;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed write sequence once taken, inputs ignored while busy
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_take_trap) begin
          state_d = c_W_MEPC;
        end else if (w_take_mret) begin
          state_d = c_R_MSTATUS;
        end
      end
      c_W_MEPC:    state_d = c_W_MCAUSE;
      c_W_MCAUSE:  state_d = c_W_MTVAL;
      c_W_MTVAL:   state_d = c_W_MSTATUS;
      c_W_MSTATUS: state_d = c_REDIRECT;
      c_R_MSTATUS: state_d = c_REDIRECT;
      c_REDIRECT:  state_d = c_IDLE;
      default:     state_d = c_IDLE;
    endcase
  end

  // Outputs: one CSR write per W_*/R_* state, redirect only in REDIRECT
  always_comb begin
    excp_csr_wen_o     = 1'b0;
    excp_csr_idx_o     = '0;
    excp_csr_wdata_o   = '0;
    excp_redirect_o    = 1'b0;
    excp_redirect_pc_o = '0;
    excp_busy_o        = ~w_idle;
    excp_stall_o       = w_take_trap | w_take_mret | ~w_idle;
    case (state_q)
      c_W_MEPC: begin
        excp_csr_wen_o   = 1'b1;
        excp_csr_idx_o   = c_ADDR_MEPC;
        excp_csr_wdata_o = epc_q;
      end
      c_W_MCAUSE: begin
        excp_csr_wen_o   = 1'b1;
        excp_csr_idx_o   = c_ADDR_MCAUSE;
        excp_csr_wdata_o = cause_q;
      end
      c_W_MTVAL: begin
        excp_csr_wen_o   = 1'b1;
        excp_csr_idx_o   = c_ADDR_MTVAL;
        excp_csr_wdata_o = tval_q;
      end
      c_W_MSTATUS: begin
        excp_csr_wen_o   = 1'b1;
        excp_csr_idx_o   = c_ADDR_MSTATUS;
        excp_csr_wdata_o = w_mst_trap;
      end
      c_R_MSTATUS: begin
        excp_csr_wen_o   = 1'b1;
        excp_csr_idx_o   = c_ADDR_MSTATUS;
        excp_csr_wdata_o = w_mst_mret;
      end
      c_REDIRECT: begin
        excp_redirect_o    = 1'b1;
        excp_redirect_pc_o = tgt_q;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire
